// File: rtl/axi_defines.sv
// rtl/axi_defines.sv - shared AXI-Lite response/protection codes and request-master state encoding
package axi_defines;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE,
        ST_HUNG
    } axil_req_state_t;

endpackage

// File: rtl/axil_req_master.sv
// rtl/axil_req_master.sv - single-outstanding AXI4-Lite master driven by a simple valid/done request port
//
// Request side : addr/data_in/be/wr/rd/valid in; data_out/done/err out.
//                done pulses one cycle per completed (or failed) request; err and
//                data_out hold until the next done.
// AXI side     : m_axil_aw*/w*/b*/ar*/r* master channels, one transaction in flight.
// Timeout      : a request not completed within TIMEOUT-1 cycles of acceptance ends
//                with done+err and parks the block in HUNG until rst.
module axil_req_master
    import axi_defines::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        be,
    input  logic              wr,
    input  logic              rd,
    input  logic              valid,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              err,

    output logic [ADDR_W-1:0] m_axil_awaddr,
    output logic [2:0]        m_axil_awprot,
    output logic              m_axil_awvalid,
    input  logic              m_axil_awready,
    output logic [DATA_W-1:0] m_axil_wdata,
    output logic [3:0]        m_axil_wstrb,
    output logic              m_axil_wvalid,
    input  logic              m_axil_wready,
    input  logic [1:0]        m_axil_bresp,
    input  logic              m_axil_bvalid,
    output logic              m_axil_bready,
    output logic [ADDR_W-1:0] m_axil_araddr,
    output logic [2:0]        m_axil_arprot,
    output logic              m_axil_arvalid,
    input  logic              m_axil_arready,
    input  logic [DATA_W-1:0] m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    input  logic              m_axil_rvalid,
    output logic              m_axil_rready
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    axil_req_state_t   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              busy;
    logic              timeout_hit;

    // Word alignment drops the byte-lane bits of the request address.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign busy = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                  (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

    // Counter is cleared on acceptance and bumped every busy cycle, so this edge
    // is the one on which it would reach TIMEOUT-1.
    assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT - 2));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = err_q;

        if (busy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (valid && (wr ^ rd)) begin
                    addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    wdata_d = data_in;
                    wstrb_d = be;
                    cnt_d   = '0;
                    if (wr) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end else if (valid && wr && rd) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end

            ST_WR: begin
                // AW and W retire independently; whichever is still pending keeps its valid.
                awvalid_d = awvalid_q & ~m_axil_awready;
                wvalid_d  = wvalid_q & ~m_axil_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_HUNG;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end

            ST_WR_RESP: begin
                if (m_axil_bvalid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = (m_axil_bresp != AXI_RESP_OKAY);
                end else if (timeout_hit) begin
                    state_d = ST_HUNG;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    bready_d = 1'b1;
                end
            end

            ST_RD_ADDR: begin
                if (m_axil_arready) begin
                    state_d   = ST_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_HUNG;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end

            ST_RD_DATA: begin
                if (m_axil_rvalid) begin
                    // Data is kept even on an error response so software can inspect it.
                    state_d = ST_DONE;
                    rdata_d = m_axil_rdata;
                    done_d  = 1'b1;
                    err_d   = (m_axil_rresp != AXI_RESP_OKAY);
                end else if (timeout_hit) begin
                    state_d = ST_HUNG;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    rready_d = 1'b1;
                end
            end

            ST_DONE: begin
                // Guard cycle: request inputs are deliberately not looked at here.
                state_d = ST_IDLE;
            end

            ST_HUNG: begin
                // A valid may not be withdrawn before its handshake, even when hung.
                awvalid_d = awvalid_q & ~m_axil_awready;
                wvalid_d  = wvalid_q & ~m_axil_wready;
                arvalid_d = arvalid_q & ~m_axil_arready;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign data_out       = rdata_q;
    assign done           = done_q;
    assign err            = err_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = AXI_PROT_DEFAULT;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = AXI_PROT_DEFAULT;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_req_master.sv
// tb/tb_axil_req_master.sv - directed self-checking bench for axil_req_master
module tb_axil_req_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  be = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data_out;
    logic        done;
    logic        err;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axil_req_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .addr(addr), .data_in(data_in), .be(be), .wr(wr), .rd(rd), .valid(valid),
        .data_out(data_out), .done(done), .err(err),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    // Slave model: 16-word memory, configurable ready latency, response codes and stalls.
    int          aw_lat = 0;
    int          w_lat = 0;
    bit          ar_block = 1'b0;
    bit          b_block = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;

    int          aw_wait, w_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    logic [31:0] mem [0:15];
    logic [31:0] last_awaddr, last_araddr;
    int          aw_count = 0, w_count = 0, ar_count = 0;
    int          aw_only_cyc = 0, any_valid_cyc = 0;

    wire aw_hs = awvalid & awready;
    wire w_hs  = wvalid & wready;
    wire ar_hs = arvalid & arready;
    wire [31:0] wr_a = aw_hs ? awaddr : aw_a;
    wire [31:0] wr_d = w_hs ? wdata : w_d;
    wire [3:0]  wr_s = w_hs ? wstrb : w_s;

    assign awready = (aw_wait >= aw_lat) && !aw_got;
    assign wready  = (w_wait >= w_lat) && !w_got;
    assign arready = !ar_block && !rvalid;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_a <= '0; w_d <= '0; w_s <= '0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
            last_awaddr <= '0; last_araddr <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (awvalid && !aw_got) begin
                if (aw_hs) begin
                    aw_got <= 1'b1; aw_a <= awaddr; aw_wait <= 0; aw_count <= aw_count + 1;
                end else begin
                    aw_wait <= aw_wait + 1;
                end
            end
            if (wvalid && !w_got) begin
                if (w_hs) begin
                    w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_wait <= 0; w_count <= w_count + 1;
                end else begin
                    w_wait <= w_wait + 1;
                end
            end
            if (awvalid && !wvalid) aw_only_cyc <= aw_only_cyc + 1;
            if (awvalid || wvalid || arvalid) any_valid_cyc <= any_valid_cyc + 1;
            if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid && !b_block) begin
                mem[wr_a[5:2]] <= merge(mem[wr_a[5:2]], wr_d, wr_s);
                bvalid <= 1'b1; bresp <= bresp_cfg;
                aw_got <= 1'b0; w_got <= 1'b0;
                last_awaddr <= wr_a;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (ar_hs) begin
                rvalid <= 1'b1; rdata <= mem[araddr[5:2]]; rresp <= rresp_cfg;
                ar_count <= ar_count + 1; last_araddr <= araddr;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required end before 500000)", $time);
        $fatal(1);
    end

    task automatic start_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wr = w; rd = r; addr = a; data_in = d; be = s; valid = 1'b1;
    endtask

    // n = number of clock edges after the accepting edge until done is seen.
    task automatic wait_done(input bit drop, input int max, output int n, output bit ok);
        ok = 1'b0; n = -1;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (k == 0 && drop) begin valid = 1'b0; wr = 1'b0; rd = 1'b0; end
            if (done) begin ok = 1'b1; n = k; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        tests++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
            fails++; $display("FAIL reset_handshake: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready});
        end
        tests++; if ({awaddr, araddr, wdata, wstrb, awprot, arprot} !== '0) begin
            fails++; $display("FAIL reset_payload: awaddr %h araddr %h wdata %h wstrb %h want all 0", awaddr, araddr, wdata, wstrb);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int n; bit ok; int aw0;
        aw0 = aw_count;
        start_req(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF);
        wait_done(1'b1, 20, n, ok);
        tests++; if (!ok || n != 2) begin fails++; $display("FAIL wr_latency: got %0d edges want 2", n); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL wr_err: got %b want 0", err); end
        tests++; if (aw_count - aw0 != 1 || last_awaddr !== 32'h100) begin
            fails++; $display("FAIL wr_txn: aw txns %0d addr %h want 1 at 00000100", aw_count - aw0, last_awaddr);
        end
        start_req(1'b0, 1'b1, 32'h103, 32'h0, 4'h0);
        wait_done(1'b1, 20, n, ok);
        tests++; if (!ok || n != 2) begin fails++; $display("FAIL rd_latency: got %0d edges want 2", n); end
        tests++; if (data_out !== 32'hDEADBEEF || err !== 1'b0) begin
            fails++; $display("FAIL rd_data: got %h err %b want deadbeef err 0", data_out, err);
        end
        tests++; if (last_araddr !== 32'h100) begin fails++; $display("FAIL rd_align: araddr %h want 00000100", last_araddr); end
        start_req(1'b1, 1'b0, 32'h100, 32'h11223344, 4'b0011);
        wait_done(1'b1, 20, n, ok);
        start_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
        wait_done(1'b1, 20, n, ok);
        tests++; if (!ok || data_out !== 32'hDEAD3344) begin
            fails++; $display("FAIL partial_strobe: got %h want dead3344", data_out);
        end
    endtask

    task automatic test_w_before_aw();
        int n; bit ok; int aw0, w0, c0;
        aw0 = aw_count; w0 = w_count; c0 = aw_only_cyc;
        aw_lat = 4; w_lat = 1;
        start_req(1'b1, 1'b0, 32'h104, 32'h0BADF00D, 4'hF);
        wait_done(1'b1, 30, n, ok);
        aw_lat = 0; w_lat = 0;
        tests++; if (!ok || n != 6) begin fails++; $display("FAIL wfirst_latency: got %0d edges want 6", n); end
        tests++; if (aw_only_cyc - c0 != 3) begin
            fails++; $display("FAIL wfirst_order: aw-only cycles %0d want 3", aw_only_cyc - c0);
        end
        tests++; if (aw_count - aw0 != 1 || w_count - w0 != 1) begin
            fails++; $display("FAIL wfirst_count: aw %0d w %0d want 1 1", aw_count - aw0, w_count - w0);
        end
        tests++; if (err !== 1'b0 || mem[1] !== 32'h0BADF00D) begin
            fails++; $display("FAIL wfirst_data: err %b mem %h want 0 0badf00d", err, mem[1]);
        end
    endtask

    task automatic test_error_resp();
        int n; bit ok;
        bresp_cfg = 2'b10;
        start_req(1'b1, 1'b0, 32'h108, 32'h55AA55AA, 4'hF);
        wait_done(1'b1, 20, n, ok);
        bresp_cfg = 2'b00;
        tests++; if (!ok || err !== 1'b1) begin fails++; $display("FAIL bresp_slverr: done %b err %b want 1 1", ok, err); end
        @(negedge clk);
        tests++; if (done !== 1'b0 || err !== 1'b1) begin
            fails++; $display("FAIL err_hold: done %b err %b want 0 1", done, err);
        end
        start_req(1'b0, 1'b1, 32'h108, 32'h0, 4'h0);
        wait_done(1'b1, 20, n, ok);
        tests++; if (!ok || err !== 1'b0 || data_out !== 32'h55AA55AA) begin
            fails++; $display("FAIL rresp_okay: err %b data %h want 0 55aa55aa", err, data_out);
        end
        rresp_cfg = 2'b11;
        start_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
        wait_done(1'b1, 20, n, ok);
        rresp_cfg = 2'b00;
        tests++; if (!ok || err !== 1'b1 || data_out !== 32'hDEAD3344) begin
            fails++; $display("FAIL rresp_decerr: err %b data %h want 1 dead3344", err, data_out);
        end
    endtask

    task automatic test_illegal();
        int n; bit ok; int v0;
        v0 = any_valid_cyc;
        start_req(1'b1, 1'b1, 32'h10C, 32'h1, 4'hF);
        wait_done(1'b1, 10, n, ok);
        tests++; if (!ok || n != 0 || err !== 1'b1) begin
            fails++; $display("FAIL illegal_done: edges %0d err %b want 0 1", n, err);
        end
        repeat (3) @(negedge clk);
        tests++; if (any_valid_cyc != v0) begin
            fails++; $display("FAIL illegal_bus: valid cycles %0d want 0", any_valid_cyc - v0);
        end
    endtask

    task automatic test_back_to_back();
        int n; bit ok; int aw0;
        aw0 = aw_count;
        start_req(1'b1, 1'b0, 32'h10C, 32'hA5A5A5A5, 4'hF);
        wait_done(1'b0, 20, n, ok);
        tests++; if (!ok || n != 2) begin fails++; $display("FAIL b2b_first: edges %0d want 2", n); end
        addr = 32'h110; data_in = 32'h5A5A5A5A;
        wait_done(1'b0, 20, n, ok);
        valid = 1'b0; wr = 1'b0;
        tests++; if (!ok || n != 3) begin fails++; $display("FAIL b2b_second: edges %0d want 3", n); end
        repeat (4) @(negedge clk);
        tests++; if (aw_count - aw0 != 2) begin fails++; $display("FAIL b2b_count: aw txns %0d want 2", aw_count - aw0); end
        tests++; if (mem[3] !== 32'hA5A5A5A5 || mem[4] !== 32'h5A5A5A5A) begin
            fails++; $display("FAIL b2b_data: mem3 %h mem4 %h want a5a5a5a5 5a5a5a5a", mem[3], mem[4]);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit ok; bit seen;
        rresp_cfg = 2'b11;
        start_req(1'b0, 1'b1, 32'h10C, 32'h0, 4'h0);
        wait_done(1'b1, 20, n, ok);
        rresp_cfg = 2'b00;
        b_block = 1'b1;
        start_req(1'b1, 1'b0, 32'h114, 32'h12345678, 4'hF);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin valid = 1'b0; wr = 1'b0; end
            if (bready) begin seen = 1'b1; break; end
        end
        tests++; if (!seen) begin fails++; $display("FAIL mid_reach_bresp: bready %b want 1", bready); end
        rst = 1'b1;
        #1;
        tests++; if ({awvalid, wvalid, arvalid, bready, rready, done, err} !== 7'b0) begin
            fails++; $display("FAIL mid_rst_ctrl: got %b want 0000000", {awvalid, wvalid, arvalid, bready, rready, done, err});
        end
        tests++; if ({data_out, awaddr, wdata, wstrb} !== '0) begin
            fails++; $display("FAIL mid_rst_data: data_out %h awaddr %h wdata %h wstrb %h want 0", data_out, awaddr, wdata, wstrb);
        end
        b_block = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_req(1'b1, 1'b0, 32'h118, 32'hCAFEF00D, 4'hF);
        wait_done(1'b1, 20, n, ok);
        tests++; if (!ok || n != 2 || err !== 1'b0) begin
            fails++; $display("FAIL post_rst_wr: edges %0d err %b want 2 0", n, err);
        end
        start_req(1'b0, 1'b1, 32'h118, 32'h0, 4'h0);
        wait_done(1'b1, 20, n, ok);
        tests++; if (!ok || data_out !== 32'hCAFEF00D) begin
            fails++; $display("FAIL post_rst_rd: got %h want cafef00d", data_out);
        end
    endtask

    task automatic test_hang();
        int n; bit ok; int aw0;
        ar_block = 1'b1;
        start_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
        wait_done(1'b1, 100, n, ok);
        tests++; if (!ok || n != 63 || err !== 1'b1) begin
            fails++; $display("FAIL hang_timeout: edges %0d err %b want 63 1", n, err);
        end
        @(negedge clk);
        tests++; if (done !== 1'b0 || arvalid !== 1'b1) begin
            fails++; $display("FAIL hang_hold: done %b arvalid %b want 0 1", done, arvalid);
        end
        aw0 = aw_count;
        start_req(1'b1, 1'b0, 32'h104, 32'h1, 4'hF);
        wait_done(1'b1, 10, n, ok);
        tests++; if (ok || aw_count != aw0 || awvalid !== 1'b0 || arvalid !== 1'b1) begin
            fails++; $display("FAIL hang_ignore: done %b awvalid %b arvalid %b want 0 0 1", ok, awvalid, arvalid);
        end
        rst = 1'b1;
        ar_block = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL hang_rst: arvalid %b want 0", arvalid); end
        start_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
        wait_done(1'b1, 20, n, ok);
        tests++; if (!ok || n != 2 || err !== 1'b0) begin
            fails++; $display("FAIL hang_recover: edges %0d err %b want 2 0", n, err);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_error_resp();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_hang();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axil_req_master.md
# axil_req_master

Single-outstanding AXI4-Lite master that turns the core memory system's simple request handshake (addr/data/be/wr/rd/valid → done) into AXI-Lite read and write transactions. It sits directly upstream of the SDRAM AXI-Lite slave and drives that slave's s_axil_* ports. It also adds response-error reporting and a bus-hang timeout.

## Interface
- ADDR_W, 32: AXI address width; also the width of `addr`.
- DATA_W, 32: data width. Fixed at XLEN.
- TIMEOUT, 64: cycles allowed from request acceptance to completion.

- clk  in  1: sole clock.
- rst  in  1: reset, asynchronous and active-high.
- addr  in  ADDR_W: byte address. Bits [1:0] are ignored.
- data_in  in  DATA_W: write data.
- be  in  4: byte enables; drive WSTRB.
- wr  in  1: write request.
- rd  in  1: read request.
- valid  in  1: request qualifier.
- data_out  out  DATA_W: last read data.
- done  out  1: one-cycle completion pulse.
- err  out  1: error status, valid with `done`.
- m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI-Lite master ports. Widths are ADDR_W, 3, DATA_W, 4, and 2.

## Operation
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE, HUNG.
- **IDLE**
  - A request is accepted on a clk edge when valid=1 and exactly one of wr or rd is 1.
  - On acceptance, latch {addr[ADDR_W-1:2], 2'b00}, data_in and be.
  - wr=1 → WR; rd=1 → RD_ADDR.
  - valid=1 with wr=rd=1: no bus activity, go to DONE with err=1.
  - valid=1 with wr=rd=0: ignored.
- **WR**
  - awvalid and wvalid are both asserted on entry.
  - Each valid drops independently after its own handshake (valid&ready). The two handshakes may complete in either order or in the same cycle.
  - When both handshakes are complete → WR_RESP.
- **WR_RESP**
  - bready=1.
  - On bvalid → DONE, with err = (bresp != OKAY).
- **RD_ADDR**
  - arvalid=1.
  - On arready → RD_DATA.
- **RD_DATA**
  - rready=1.
  - On rvalid: capture rdata into data_out, set err = (rresp != OKAY), → DONE.
  - data_out is captured even when rresp is an error.
- **DONE**
  - done=1 for exactly this one cycle, then → IDLE.
  - Request inputs sampled at the edge leaving DONE are ignored. This guard cycle lets the requester drop or change valid after seeing done without causing a duplicate transaction.
- **Timeout**
  - A counter clears on acceptance and increments in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT-1 without completion: done=1 and err=1 for one cycle, then → HUNG.
  - In HUNG, any AXI valid that is still asserted stays asserted; AXI rules forbid withdrawing it.
  - HUNG accepts no requests. Only rst exits HUNG.
- awprot and arprot are always 3'b000.
- bready is high only in WR_RESP; rready is high only in RD_DATA.
- err holds its value until the next done.

## Timing
- Reset values: all AXI valid and ready outputs 0, done=0, err=0, data_out=0, address/data/strobe outputs 0, state IDLE, counter 0.
- rst is asynchronous and may assert mid-transaction. It drops every output to its reset value immediately.
- All outputs are registered.
- Best-case write latency, with all readies high: accept edge → awvalid/wvalid visible next cycle → bvalid the cycle after → done. That is 4 cycles from acceptance to done.
- Best-case read latency is likewise 4 cycles (accept, AR, R, DONE).
- Minimum spacing from one done pulse to the next acceptance is 1 cycle (the guard).

## Structure
- Shared package axi_defines holds:
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR (2-bit).
  - AXI_PROT_DEFAULT = 3'b000.
  - The axil_req_state_t enum.
- The timeout counter stays inline; no sub-module is needed.
- The block connects to axi_lite_interface master signals, and the AXI port names match that interface.

## Test plan
- **Write then read:** write 0xDEADBEEF to 0x100 with be=4'hF, then read 0x100 against a zero-wait slave → data_out=0xDEADBEEF, err=0, each operation 4 cycles.
- **W handshake before AW:** slave asserts wready 3 cycles before awready → wvalid drops first, exactly one transaction, done after bvalid.
- **Error responses:** slave returns bresp=SLVERR on a write → done with err=1. Next read returns rresp=OKAY → err=0.
- **Illegal request:** wr=rd=valid=1 → no AXI valid ever asserts, done with err=1 after 1 cycle.
- **Hang:** slave never asserts arready on a read (TIMEOUT=64) → done and err pulse 63 cycles after acceptance, arvalid stays 1, further requests ignored until rst.
- **Back-to-back and reset:**
  - Back-to-back writes with valid held high across the guard cycle → exactly one AXI write per request.
  - rst pulsed while in WR_RESP → all outputs 0 immediately, and the next request completes normally.
